// File: rtl/mac_layer_scheduler.sv
// -----------------------------------------------------------------------------
// mac_layer_scheduler
//   Time-multiplexes one shared binary-weight MAC across N_NEURONS neurons.
//   Each timestep latches the input spike vector and threshold, walks idx over
//   all neurons (one per cycle), integrates the MAC sum with leak into the
//   membrane potential u[idx], and fires when u reaches threshold. Spike bits
//   are collected in a shadow register and published as a whole at the end.
//
//   Optional feature macro: MAC_SCHED_SUBTRACT_RESET_EN
//     defined   : on spike, u = s - threshold (residual kept)
//     undefined : on spike, u = 0
//
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high reset
//   w_wr_en     in   write weight vector (honoured only in IDLE)
//   w_wr_addr   in   neuron index for the weight write
//   w_wr_data   in   weight bits (1 = +1, 0 = -1)
//   start       in   begin a timestep (honoured only in IDLE)
//   x_in        in   input spikes, latched at start
//   threshold   in   signed firing threshold (>0), latched at start
//   mac_w       out  weights to the MAC (weight[idx] in RUN, else 0)
//   mac_x       out  spikes to the MAC (latched x in RUN, else 0)
//   mac_y       in   signed MAC sum, combinational in the same cycle
//   busy        out  high in RUN
//   done        out  one-cycle pulse, spikes_out valid
//   spikes_out  out  spike per neuron for the last completed timestep
// -----------------------------------------------------------------------------
module mac_layer_scheduler #(
    parameter int N_STAGE    = 2,
    parameter int N_NEURONS  = 4,
    parameter int U_W        = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          w_wr_en,
    input  logic [$clog2(N_NEURONS)-1:0]  w_wr_addr,
    input  logic [2**N_STAGE-1:0]         w_wr_data,
    input  logic                          start,
    input  logic [2**N_STAGE-1:0]         x_in,
    input  logic signed [U_W-1:0]         threshold,
    output logic [2**N_STAGE-1:0]         mac_w,
    output logic [2**N_STAGE-1:0]         mac_x,
    input  logic signed [N_STAGE+1:0]     mac_y,
    output logic                          busy,
    output logic                          done,
    output logic [N_NEURONS-1:0]          spikes_out
);

    localparam int M     = 2**N_STAGE;
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int S_W   = U_W + 2;   // headroom for u - leak + y before clamping

    localparam logic signed [S_W-1:0] S_MAX = S_W'((2**(U_W-1)) - 1);
    localparam logic signed [S_W-1:0] S_MIN = -S_MAX - S_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state, next_state;
    logic [IDX_W-1:0]       idx;
    logic signed [U_W-1:0]  u      [N_NEURONS];
    logic [M-1:0]           weight [N_NEURONS];
    logic [M-1:0]           x_lat;
    logic signed [U_W-1:0]  thr_lat;
    logic [N_NEURONS-1:0]   shadow;

    logic signed [U_W-1:0]  u_cur, leak, s_sat, u_new;
    logic signed [S_W-1:0]  s_raw;
    logic                   fire, last;
    logic [N_NEURONS-1:0]   spikes_next;

    // ---------------- integrate / fire for the neuron at idx ----------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        u_cur       = u[idx];
        leak        = '0;
        if (LEAK_SHIFT != 0) begin
            leak = u_cur >>> LEAK_SHIFT;   // arithmetic: negative u leaks toward 0
        end
        s_raw = S_W'(u_cur) - S_W'(leak) + S_W'(mac_y);
        if (s_raw > S_MAX) begin
            s_sat = S_MAX[U_W-1:0];
        end else if (s_raw < S_MIN) begin
            s_sat = S_MIN[U_W-1:0];
        end else begin
            s_sat = s_raw[U_W-1:0];
        end
        fire = (s_sat >= thr_lat);
`ifdef MAC_SCHED_SUBTRACT_RESET_EN
        // threshold > 0 and s >= threshold, so the residual cannot overflow
        u_new = fire ? (s_sat - thr_lat) : s_sat;
`else
        u_new = fire ? '0 : s_sat;
`endif
        spikes_next      = shadow;
        spikes_next[idx] = fire;
        last             = (idx == IDX_W'(N_NEURONS - 1));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign mac_w = (state == RUN) ? weight[idx] : '0;
    assign mac_x = (state == RUN) ? x_lat       : '0;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: u and weight are register arrays that must read as zero after reset
            // (a mid-run reset discards partial updates), so they are cleared here.
            for (int i = 0; i < N_NEURONS; i++) begin
                u[i]      <= '0;
                weight[i] <= '0;
            end
            idx        <= '0;
            x_lat      <= '0;
            thr_lat    <= '0;
            shadow     <= '0;
            spikes_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a write and a start on the same edge both land; the run sees the new weight
                    if (w_wr_en) begin
                        weight[w_wr_addr] <= w_wr_data;
                    end
                    if (start) begin
                        x_lat   <= x_in;
                        thr_lat <= threshold;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    u[idx] <= u_new;
                    shadow <= spikes_next;
                    if (last) begin
                        idx        <= '0;
                        spikes_out <= spikes_next;   // publish the whole timestep at once
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_layer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mac_layer_scheduler
//   Two instances share all inputs: dut0 with LEAK_SHIFT=0 and dut3 with
//   LEAK_SHIFT=3. Each has its own behavioural binary-weight MAC. A reference
//   model of u[] pushes expected spike vectors when a timestep starts; they are
//   popped and compared when done is observed.
// -----------------------------------------------------------------------------
module tb_mac_layer_scheduler;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_wr_en;
    logic [1:0] w_wr_addr;
    logic [3:0] w_wr_data;
    logic       start;
    logic [3:0] x_in;
    logic [7:0] threshold;

    logic [3:0] mac_w0, mac_x0, mac_w3, mac_x3;
    logic [3:0] mac_y0, mac_y3;
    logic       busy0, done0, busy3, done3;
    logic [3:0] spk0, spk3;

    int checks = 0;
    int errors = 0;

    // reference state
    int         um [2][N];
    logic [3:0] wm [N];
    logic [3:0] q0 [$];
    logic [3:0] q3 [$];

    always #5 clk = ~clk;

    function automatic logic [3:0] mac_ref(input logic [3:0] w, input logic [3:0] x);
        int y;
        y = 0;
        for (int j = 0; j < 4; j++) begin
            if (x[j]) y += w[j] ? 1 : -1;
        end
        return 4'(y);
    endfunction

    assign mac_y0 = mac_ref(mac_w0, mac_x0);
    assign mac_y3 = mac_ref(mac_w3, mac_x3);

    mac_layer_scheduler #(.N_STAGE(2), .N_NEURONS(N), .U_W(8), .LEAK_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data), .start(start), .x_in(x_in), .threshold(threshold),
        .mac_w(mac_w0), .mac_x(mac_x0), .mac_y(mac_y0),
        .busy(busy0), .done(done0), .spikes_out(spk0)
    );

    mac_layer_scheduler #(.N_STAGE(2), .N_NEURONS(N), .U_W(8), .LEAK_SHIFT(3)) dut3 (
        .clk(clk), .reset(reset), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
        .w_wr_data(w_wr_data), .start(start), .x_in(x_in), .threshold(threshold),
        .mac_w(mac_w3), .mac_x(mac_x3), .mac_y(mac_y3),
        .busy(busy3), .done(done3), .spikes_out(spk3)
    );

    // one timestep of the reference model; pushes the expected spike vectors
    task automatic model_timestep(input logic [3:0] x, input int thr);
        logic [3:0] e [2];
        int y, l, s;
        for (int d = 0; d < 2; d++) begin
            e[d] = '0;
            for (int i = 0; i < N; i++) begin
                y = $signed(mac_ref(wm[i], x));
                l = (d == 0) ? 0 : (um[d][i] >>> 3);
                s = um[d][i] - l + y;
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                if (s >= thr) begin
                    e[d][i] = 1'b1;
`ifdef MAC_SCHED_SUBTRACT_RESET_EN
                    um[d][i] = s - thr;
`else
                    um[d][i] = 0;
`endif
                end else begin
                    um[d][i] = s;
                end
            end
        end
        q0.push_back(e[0]);
        q3.push_back(e[1]);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            um[0][i] = 0;
            um[1][i] = 0;
            wm[i]    = '0;
        end
        q0.delete();
        q3.delete();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start     = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        x_in      = '0;
        threshold = '0;
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic write_weight(input logic [1:0] a, input logic [3:0] d);
        w_wr_en   = 1'b1;
        w_wr_addr = a;
        w_wr_data = d;
        wm[a]     = d;
        @(posedge clk); #1;
        w_wr_en = 1'b0;
    endtask

    // Drives one timestep from IDLE. inject = 0..N-1 pulses start plus a weight
    // write during that RUN cycle, inject = N pulses them during DONE, -1 none.
    task automatic run_step(input logic [3:0] x, input int thr, input logic wr,
                            input logic [1:0] waddr, input logic [3:0] wdata,
                            input int inject);
        logic [3:0] e0, e3;
        w_wr_en   = wr;
        w_wr_addr = waddr;
        w_wr_data = wdata;
        start     = 1'b1;
        x_in      = x;
        threshold = 8'(thr);
        if (wr) wm[waddr] = wdata;
        model_timestep(x, thr);
        @(posedge clk); #1;
        start     = 1'b0;
        w_wr_en   = 1'b0;
        x_in      = ~x;      // latched copy must be used, not the live input
        threshold = '0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if ({busy0, busy3, done0, done3, mac_w0, mac_x0, mac_w3, mac_x3} !==
                {4'b1100, wm[i], x, wm[i], x}) begin
                errors++;
                $display("FAIL run_cycle idx=%0d got=%h expected=%h", i,
                         {busy0, busy3, done0, done3, mac_w0, mac_x0, mac_w3, mac_x3},
                         {4'b1100, wm[i], x, wm[i], x});
            end
            if (inject == i) begin
                start     = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = 2'd2;
                w_wr_data = ~wm[2];
            end
            @(posedge clk); #1;
            start   = 1'b0;
            w_wr_en = 1'b0;
        end
        checks++;
        if ({busy0, busy3, done0, done3, mac_w0, mac_x0, mac_w3, mac_x3} !== {4'b0011, 16'h0}) begin
            errors++;
            $display("FAIL done_cycle got=%h expected=%h",
                     {busy0, busy3, done0, done3, mac_w0, mac_x0, mac_w3, mac_x3}, {4'b0011, 16'h0});
        end
        checks++;
        if (q0.size() == 0 || q3.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%0d/%0d expected=nonzero", q0.size(), q3.size());
        end else begin
            e0 = q0.pop_front();
            e3 = q3.pop_front();
            if ({spk0, spk3} !== {e0, e3}) begin
                errors++;
                $display("FAIL spikes_out got=%b/%b expected=%b/%b", spk0, spk3, e0, e3);
            end
        end
        if (inject == N) begin
            start     = 1'b1;
            w_wr_en   = 1'b1;
            w_wr_addr = 2'd2;
            w_wr_data = ~wm[2];
        end
        @(posedge clk); #1;
        start   = 1'b0;
        w_wr_en = 1'b0;
        checks++;
        if ({busy0, busy3, done0, done3} !== 4'b0000) begin
            errors++;
            $display("FAIL done_pulse_end got=%b expected=0000", {busy0, busy3, done0, done3});
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        w_wr_data = '0;
        x_in      = 4'hF;
        threshold = 8'd10;
        model_clear();
        #12;
        checks++;
        if ({busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h expected=0",
                     {busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3} !== 28'h0) begin
            errors++;
            $display("FAIL idle_after_reset got=%h expected=0",
                     {busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3});
        end
    endtask

    // u[0]: 4, 8, then fires; later steps expose the reset-on-spike rule
    task automatic test_accumulate();
        do_reset();
        write_weight(2'd0, 4'b1111);
        for (int t = 0; t < 5; t++) run_step(4'b1111, 10, 1'b0, 2'd0, 4'd0, -1);
    endtask

    // distinct weights so mac_w visibly steps through weight[0..3]
    task automatic test_timing();
        do_reset();
        for (int i = 0; i < N; i++) write_weight(2'(i), 4'(1 << i));
        run_step(4'b1011, 1, 1'b0, 2'd0, 4'd0, -1);
        run_step(4'b0110, 1, 1'b0, 2'd0, 4'd0, -1);
    endtask

    // y = -4 drives u to the negative rail; a wrapping sum would then fire
    task automatic test_saturation();
        do_reset();
        for (int t = 0; t < 33; t++) run_step(4'b1111, 10, 1'b0, 2'd0, 4'd0, -1);
        write_weight(2'd1, 4'b1111);
        for (int t = 0; t < 2; t++) run_step(4'b1111, 10, 1'b0, 2'd0, 4'd0, -1);
    endtask

    // with leak 3: u[0] 4, 8, 11, 14, 15, 16, then y=0 gives 14; then 15 < 16
    task automatic test_leak();
        do_reset();
        write_weight(2'd0, 4'b1111);
        for (int t = 0; t < 4; t++) run_step(4'b1111, 100, 1'b0, 2'd0, 4'd0, -1);
        for (int t = 0; t < 2; t++) run_step(4'b0011, 100, 1'b0, 2'd0, 4'd0, -1);
        run_step(4'b0000, 100, 1'b0, 2'd0, 4'd0, -1);
        run_step(4'b0011, 16, 1'b0, 2'd0, 4'd0, -1);
    endtask

    task automatic test_ignore_and_same_edge();
        do_reset();
        for (int i = 0; i < N; i++) write_weight(2'(i), 4'(4'b1001 ^ i));
        run_step(4'b1111, 3, 1'b0, 2'd0, 4'd0, 1);
        run_step(4'b1101, 3, 1'b0, 2'd0, 4'd0, N);
        @(posedge clk); #1;
        checks++;
        if ({busy0, busy3} !== 2'b00) begin
            errors++;
            $display("FAIL start_in_done_ignored got=%b expected=00", {busy0, busy3});
        end
        run_step(4'b1111, 3, 1'b1, 2'd0, 4'b0101, -1);
        run_step(4'b1110, 3, 1'b1, 2'd3, 4'b1111, -1);
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        write_weight(2'd0, 4'b1111);
        run_step(4'b1111, 4, 1'b0, 2'd0, 4'd0, -1);   // leaves spikes_out[0]=1
        start     = 1'b1;
        x_in      = 4'b1111;
        threshold = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                             // now idx = 2
        checks++;
        if ({busy0, busy3} !== 2'b11) begin
            errors++;
            $display("FAIL busy_before_abort got=%b expected=11", {busy0, busy3});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3} !== 28'h0) begin
            errors++;
            $display("FAIL async_abort got=%h expected=0",
                     {busy0, done0, mac_w0, mac_x0, spk0, busy3, done3, mac_w3, mac_x3, spk3});
        end
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        write_weight(2'd0, 4'b1111);
        for (int t = 0; t < 3; t++) run_step(4'b1111, 10, 1'b0, 2'd0, 4'd0, -1);
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_timing();
        test_saturation();
        test_leak();
        test_ignore_and_same_edge();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

endmodule
